// File: rtl/cpu_exec_units.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_exec_units                                             |
// | Description : Registered RV32I execute support: ALU with branch flags,   |
// |               immediate extender and load-data extender behind one       |
// |               capture stage. Define CPU_EXEC_STRICT_EN to zero outputs   |
// |               on unsupported codes and raise err.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cpu_exec_units (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_control,
    input  logic [24:0] imm_data,
    input  logic [2:0]  imm_src,
    input  logic [31:0] load_data,
    input  logic [2:0]  data_ext_control,
    output logic        out_valid,
    output logic [31:0] alu_result,
    output logic        alu_zero,
    output logic        alu_lt,
    output logic        alu_borrow,
    output logic [31:0] imm_ext,
    output logic [31:0] data_ext,
    output logic        err
);

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_SLL  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_OR   = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;

    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_U = 3'd3;
    localparam logic [2:0] c_IMM_J = 3'd4;

    localparam logic [2:0] c_LD_B  = 3'b000;
    localparam logic [2:0] c_LD_H  = 3'b001;
    localparam logic [2:0] c_LD_W  = 3'b010;
    localparam logic [2:0] c_LD_BU = 3'b100;
    localparam logic [2:0] c_LD_HU = 3'b101;

    logic [4:0]  w_shamt;
    logic        w_lt;
    logic        w_borrow;
    logic [31:0] w_alu_result;
    logic [31:0] w_imm_ext;
    logic [31:0] w_data_ext;
    logic        w_err;

    logic        r_out_valid;
    logic [31:0] r_alu_result;
    logic        r_alu_zero;
    logic        r_alu_lt;
    logic        r_alu_borrow;
    logic [31:0] r_imm_ext;
    logic [31:0] r_data_ext;
    logic        r_err;

    assign w_shamt  = alu_b[4:0];
    // Flags compare the raw operands so branches work regardless of the op.
    assign w_lt     = $signed(alu_a) < $signed(alu_b);
    assign w_borrow = alu_a < alu_b;

    always_comb begin
        w_alu_result = 32'd0;
        case (alu_control)
            c_ALU_ADD:  w_alu_result = alu_a + alu_b;
            c_ALU_SUB:  w_alu_result = alu_a - alu_b;
            c_ALU_SLL:  w_alu_result = alu_a << w_shamt;
            c_ALU_SLT:  w_alu_result = {31'd0, w_lt};
            c_ALU_SLTU: w_alu_result = {31'd0, w_borrow};
            c_ALU_XOR:  w_alu_result = alu_a ^ alu_b;
            c_ALU_SRL:  w_alu_result = alu_a >> w_shamt;
            c_ALU_SRA:  w_alu_result = $unsigned($signed(alu_a) >>> w_shamt);
            c_ALU_OR:   w_alu_result = alu_a | alu_b;
            c_ALU_AND:  w_alu_result = alu_a & alu_b;
            default:    w_alu_result = 32'd0;
        endcase
    end

    // imm_data[k] carries instr[k+7].
    always_comb begin
        w_imm_ext = 32'd0;
        case (imm_src)
            c_IMM_I: w_imm_ext = {{20{imm_data[24]}}, imm_data[24:13]};
            c_IMM_S: w_imm_ext = {{20{imm_data[24]}}, imm_data[24:18], imm_data[4:0]};
            c_IMM_B: w_imm_ext = {{19{imm_data[24]}}, imm_data[24], imm_data[0],
                                  imm_data[23:18], imm_data[4:1], 1'b0};
            c_IMM_U: w_imm_ext = {imm_data[24:5], 12'd0};
            c_IMM_J: w_imm_ext = {{11{imm_data[24]}}, imm_data[24], imm_data[12:5],
                                  imm_data[13], imm_data[23:14], 1'b0};
            default: w_imm_ext = 32'd0;
        endcase
    end

    always_comb begin
        w_data_ext = load_data;
        case (data_ext_control)
            c_LD_B:  w_data_ext = {{24{load_data[7]}}, load_data[7:0]};
            c_LD_H:  w_data_ext = {{16{load_data[15]}}, load_data[15:0]};
            c_LD_W:  w_data_ext = load_data;
            c_LD_BU: w_data_ext = {24'd0, load_data[7:0]};
            c_LD_HU: w_data_ext = {16'd0, load_data[15:0]};
`ifdef CPU_EXEC_STRICT_EN
            default: w_data_ext = 32'd0;
`else
            default: w_data_ext = load_data;
`endif
        endcase
    end

`ifdef CPU_EXEC_STRICT_EN
    logic w_alu_bad;
    logic w_imm_bad;
    logic w_ld_bad;

    always_comb begin
        w_alu_bad = 1'b1;
        case (alu_control)
            c_ALU_ADD, c_ALU_SUB, c_ALU_SLL, c_ALU_SLT, c_ALU_SLTU,
            c_ALU_XOR, c_ALU_SRL, c_ALU_SRA, c_ALU_OR, c_ALU_AND: w_alu_bad = 1'b0;
            default: w_alu_bad = 1'b1;
        endcase
    end

    assign w_imm_bad = imm_src > c_IMM_J;
    assign w_ld_bad  = (data_ext_control == 3'b011) || (data_ext_control[2:1] == 2'b11);
    assign w_err     = w_alu_bad | w_imm_bad | w_ld_bad;
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_alu_result <= 32'd0;
            r_alu_zero   <= 1'b0;
            r_alu_lt     <= 1'b0;
            r_alu_borrow <= 1'b0;
            r_imm_ext    <= 32'd0;
            r_data_ext   <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_alu_result <= w_alu_result;
                r_alu_zero   <= (w_alu_result == 32'd0);
                r_alu_lt     <= w_lt;
                r_alu_borrow <= w_borrow;
                r_imm_ext    <= w_imm_ext;
                r_data_ext   <= w_data_ext;
                r_err        <= w_err;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_result = r_alu_result;
    assign alu_zero   = r_alu_zero;
    assign alu_lt     = r_alu_lt;
    assign alu_borrow = r_alu_borrow;
    assign imm_ext    = r_imm_ext;
    assign data_ext   = r_data_ext;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_exec_units.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_exec_units                                          |
// | Description : Directed table-driven bench for cpu_exec_units, plus reset |
// |               and hold sequences. Honours CPU_EXEC_STRICT_EN.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cpu_exec_units;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [31:0] instr;
        logic [2:0]  isrc;
        logic [31:0] ld;
        logic [2:0]  dctl;
        logic [31:0] res;
        logic        z;
        logic        lt;
        logic        bo;
        logic [31:0] imm;
        logic [31:0] dat;
        logic        err_s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [24:0] imm_data;
    logic [2:0]  imm_src;
    logic [31:0] load_data;
    logic [2:0]  data_ext_control;
    logic        out_valid;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_borrow;
    logic [31:0] imm_ext;
    logic [31:0] data_ext;
    logic        err;

    int errors = 0;
    int checks = 0;
    vec_t vq[$];

    cpu_exec_units dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .imm_data(imm_data), .imm_src(imm_src),
        .load_data(load_data), .data_ext_control(data_ext_control),
        .out_valid(out_valid), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_lt(alu_lt), .alu_borrow(alu_borrow), .imm_ext(imm_ext),
        .data_ext(data_ext), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld);
        in_valid         = vld;
        alu_a            = v.a;
        alu_b            = v.b;
        alu_control      = v.ctl;
        imm_data         = v.instr[31:7];
        imm_src          = v.isrc;
        load_data        = v.ld;
        data_ext_control = v.dctl;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_zero"}, {24'd0, out_valid, alu_zero, alu_lt, alu_borrow, err, 3'd0}, 32'd0);
        check({name, "_res"}, alu_result, 32'd0);
        check({name, "_imm"}, imm_ext, 32'd0);
        check({name, "_dat"}, data_ext, 32'd0);
    endtask

    task automatic check_vec(input string name, input vec_t v);
        logic [31:0] exp_dat;
        logic        exp_err;
        exp_dat = v.dat;
        exp_err = 1'b0;
`ifdef CPU_EXEC_STRICT_EN
        exp_err = v.err_s;
        if (v.dctl == 3'b011 || v.dctl == 3'b110 || v.dctl == 3'b111) exp_dat = 32'd0;
`endif
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_res"}, alu_result, v.res);
        check({name, "_flags"}, {29'd0, alu_zero, alu_lt, alu_borrow}, {29'd0, v.z, v.lt, v.bo});
        check({name, "_imm"}, imm_ext, v.imm);
        check({name, "_dat"}, data_ext, exp_dat);
        check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        vec_t hv;
        //            a             b             ctl      instr         src   load          dctl    res           z     lt    bo    imm           dat           err_s
        vq.push_back('{32'd5,        32'd7,        4'b1000, 32'hFFF00093, 3'd0, 32'h000080F0, 3'b000, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b0});
        vq.push_back('{32'hFFFFFFFF, 32'd1,        4'b1000, 32'h123452B7, 3'd3, 32'h000080F0, 3'b100, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 32'h12345000, 32'h000000F0, 1'b0});
        vq.push_back('{32'd9,        32'd9,        4'b1000, 32'hFE000EE3, 3'd2, 32'h000080F0, 3'b001, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'hFFFF80F0, 1'b0});
        vq.push_back('{32'h80000000, 32'd4,        4'b1101, 32'h0080006F, 3'd4, 32'h000080F0, 3'b101, 32'hF8000000, 1'b0, 1'b1, 1'b0, 32'h00000008, 32'h000080F0, 1'b0});
        vq.push_back('{32'h80000000, 32'd4,        4'b0101, 32'h0080006F, 3'd5, 32'h000080F0, 3'b010, 32'h08000000, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h000080F0, 1'b1});
        vq.push_back('{32'd3,        32'd5,        4'b0000, 32'hFE512E23, 3'd1, 32'h000080F0, 3'b110, 32'h00000008, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h000080F0, 1'b1});
        vq.push_back('{32'h00001234, 32'd1,        4'b1111, 32'h00100093, 3'd0, 32'h0000007F, 3'b000, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000001, 32'h0000007F, 1'b1});
        vq.push_back('{32'd1,        32'h00000023, 4'b0001, 32'hFFFFF037, 3'd3, 32'hFFFF7FFF, 3'b001, 32'h00000008, 1'b0, 1'b1, 1'b1, 32'hFFFFF000, 32'h00007FFF, 1'b0});
        vq.push_back('{32'hFFFFFFFE, 32'd1,        4'b0010, 32'h7FF00013, 3'd0, 32'h12345678, 3'b010, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h000007FF, 32'h12345678, 1'b0});
        vq.push_back('{32'hFFFFFFFE, 32'd1,        4'b0011, 32'h00000000, 3'd0, 32'h12345678, 3'b111, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h12345678, 1'b1});
        vq.push_back('{32'h0000F0F0, 32'h00000FF0, 4'b0100, 32'h00000000, 3'd0, 32'h00000000, 3'b000, 32'h0000FF00, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0});
        vq.push_back('{32'h0000F0F0, 32'h00000FF0, 4'b0110, 32'h00000000, 3'd0, 32'h00000000, 3'b000, 32'h0000FFF0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0});
        vq.push_back('{32'h0000F0F0, 32'h00000FF0, 4'b0111, 32'h00000000, 3'd0, 32'h00000000, 3'b000, 32'h000000F0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0});

        // Power-on reset, outputs cleared before any clock edge.
        rst = 1'b1;
        drive(vq[0], 1'b1);
        #1;
        check_all_zero("por");
        @(posedge clk); #1;
        check_all_zero("por_held");
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i], 1'b1);
            @(posedge clk); #1;
            check_vec($sformatf("vec%0d", i), vq[i]);
        end

        // Hold: capture an add, then change everything with in_valid low.
        drive(vq[5], 1'b1);
        @(posedge clk); #1;
        check_vec("hold_cap", vq[5]);
        hv = vq[0];
        drive(hv, 1'b0);
        @(posedge clk); #1;
        check("hold_valid", {31'd0, out_valid}, 32'd0);
        check("hold_res", alu_result, 32'h00000008);
        check("hold_flags", {29'd0, alu_zero, alu_lt, alu_borrow}, 32'b011);
        check("hold_imm", imm_ext, 32'hFFFFFFFC);
        @(posedge clk); #1;
        check("hold_res2", alu_result, 32'h00000008);

        // Mid-stream async reset with in_valid high.
        drive(vq[3], 1'b1);
        @(posedge clk); #1;
        check_vec("pre_rst", vq[3]);
        drive(vq[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk); #1;
        check_all_zero("mid_rst_held");
        rst = 1'b0;
        #1;
        check_all_zero("post_rst_release");
        @(posedge clk); #1;
        check_vec("first_cap", vq[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
